// File: rtl/sram_dual_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_dual_port_arbiter_if
//
// Bundles the client request/grant signals and the SRAM macro pins that
// surround sram_dual_port_arbiter.
//
// Handshake: a client raises *_req and holds it together with its address/
// data/mask until the matching *_gnt bit is high in the same cycle. The
// transfer happens at the rising edge that closes that cycle. The client may
// drop or change its request in the following cycle. Read data comes back
// with rd_valid one cycle after rd_gnt, tagged by rd_id.
//
// Modports:
//   slave  - the arbiter (takes requests and Q, drives grants and SRAM pins)
//   master - the environment (load/store clients plus the SRAM macro)
// -----------------------------------------------------------------------------
interface sram_dual_port_arbiter_if #(
   parameter int WIDTH    = 128,
   parameter int NUM_ROWS = 4096,
   parameter int NUM_WR   = 2,
   parameter int NUM_RD   = 2
);
   localparam int AW = $clog2(NUM_ROWS);
   localparam int IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

   // write clients
   logic [NUM_WR-1:0]       wr_req;
   logic [NUM_WR*AW-1:0]    wr_addr;
   logic [NUM_WR*WIDTH-1:0] wr_data;
   logic [NUM_WR*WIDTH-1:0] wr_mask;
   logic [NUM_WR-1:0]       wr_gnt;
   // read clients
   logic [NUM_RD-1:0]       rd_req;
   logic [NUM_RD*AW-1:0]    rd_addr;
   logic [NUM_RD-1:0]       rd_gnt;
   logic                    rd_valid;
   logic [IW-1:0]           rd_id;
   logic [WIDTH-1:0]        rd_data;
   // SRAM macro pins
   logic                    REB;
   logic                    WEB;
   logic [AW-1:0]           AA;
   logic [AW-1:0]           AB;
   logic [WIDTH-1:0]        D;
   logic [WIDTH-1:0]        M;
   logic [WIDTH-1:0]        Q;

   modport slave (
      input  wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, Q,
      output wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, REB, WEB, AA, AB, D, M
   );

   modport master (
      output wr_req, wr_addr, wr_data, wr_mask, rd_req, rd_addr, Q,
      input  wr_gnt, rd_gnt, rd_valid, rd_id, rd_data, REB, WEB, AA, AB, D, M
   );
endinterface

// File: rtl/sram_dual_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_dual_port_arbiter
//
// Shares one two-port SRAM macro (write port AA/D/M/WEB, read port AB/REB/Q)
// between NUM_WR write clients and NUM_RD read clients. Each port has its own
// round-robin pointer and the two ports are arbitrated independently, so a
// read and a write can both be granted in the same cycle. Grants and SRAM pins
// are combinational from the requests and pointers. Read data returns one
// cycle after the grant with rd_valid and the requester index in rd_id.
//
// Ports:
//   CLK  - clock, all state on the rising edge
//   RST  - asynchronous active-high reset; grants are forced low while high
//   bus  - sram_dual_port_arbiter_if.slave: client requests/grants, read
//          response and SRAM macro pins
//
// Build option:
//   SRAM_RAW_FORWARD_EN - when defined, a same-cycle read and write to the
//   same row returns the newly written data instead of the SRAM's pre-write
//   data. When undefined no forwarding registers exist and rd_data = Q.
// -----------------------------------------------------------------------------
module sram_dual_port_arbiter #(
   parameter int WIDTH    = 128,
   parameter int NUM_ROWS = 4096,
   parameter int NUM_WR   = 2,
   parameter int NUM_RD   = 2
) (
   input logic                   CLK,
   input logic                   RST,
   sram_dual_port_arbiter_if.slave bus
);
   localparam int AW  = $clog2(NUM_ROWS);
   localparam int IW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
   localparam logic [WPW-1:0] WR_LAST = WPW'(NUM_WR - 1);
   localparam logic [IW-1:0]  RD_LAST = IW'(NUM_RD - 1);

   logic [WPW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WPW-1:0]    wr_idx, wr_sel;
   logic              wr_found;
   logic [IW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [IW-1:0]     rd_idx, rd_sel;
   logic              rd_found;
   logic              rd_valid_q, rd_valid_d;
   logic [IW-1:0]     rd_id_q, rd_id_d;

   logic [NUM_WR-1:0] wr_gnt_c;
   logic [NUM_RD-1:0] rd_gnt_c;
   logic              web_c, reb_c;
   logic [AW-1:0]     aa_c, ab_c;
   logic [WIDTH-1:0]  d_c, m_c;

   // Write arbitration: walk the clients starting at the pointer, wrapping,
   // and take the first request. Reset masks every grant.
   always_comb begin : wr_arb
      wr_idx   = wr_ptr_q;
      wr_sel   = '0;
      wr_found = 1'b0;
      for (int i = 0; i < NUM_WR; i++) begin
         if (!wr_found && bus.wr_req[wr_idx]) begin
            wr_found = 1'b1;
            wr_sel   = wr_idx;
         end
         wr_idx = (wr_idx == WR_LAST) ? '0 : wr_idx + WPW'(1);
      end
      if (RST) wr_found = 1'b0;
      wr_ptr_d = wr_ptr_q;
      if (wr_found) wr_ptr_d = (wr_sel == WR_LAST) ? '0 : wr_sel + WPW'(1);
   end

   always_comb begin : rd_arb
      rd_idx   = rd_ptr_q;
      rd_sel   = '0;
      rd_found = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (!rd_found && bus.rd_req[rd_idx]) begin
            rd_found = 1'b1;
            rd_sel   = rd_idx;
         end
         rd_idx = (rd_idx == RD_LAST) ? '0 : rd_idx + IW'(1);
      end
      if (RST) rd_found = 1'b0;
      rd_ptr_d = rd_ptr_q;
      if (rd_found) rd_ptr_d = (rd_sel == RD_LAST) ? '0 : rd_sel + IW'(1);
      // The response slot follows the grant by exactly one cycle.
      rd_valid_d = rd_found;
      rd_id_d    = rd_found ? rd_sel : rd_id_q;
   end

   // SRAM pin muxing; an idle port parks its address/data/mask at zero.
   always_comb begin : port_mux
      wr_gnt_c = '0;
      rd_gnt_c = '0;
      web_c    = 1'b1;
      reb_c    = 1'b1;
      aa_c     = '0;
      ab_c     = '0;
      d_c      = '0;
      m_c      = '0;
      if (wr_found) begin
         wr_gnt_c[wr_sel] = 1'b1;
         web_c            = 1'b0;
         aa_c             = bus.wr_addr[wr_sel*AW +: AW];
         d_c              = bus.wr_data[wr_sel*WIDTH +: WIDTH];
         m_c              = bus.wr_mask[wr_sel*WIDTH +: WIDTH];
      end
      if (rd_found) begin
         rd_gnt_c[rd_sel] = 1'b1;
         reb_c            = 1'b0;
         ab_c             = bus.rd_addr[rd_sel*AW +: AW];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_id_q    <= rd_id_d;
      end
   end

   assign bus.wr_gnt   = wr_gnt_c;
   assign bus.rd_gnt   = rd_gnt_c;
   assign bus.WEB      = web_c;
   assign bus.REB      = reb_c;
   assign bus.AA       = aa_c;
   assign bus.AB       = ab_c;
   assign bus.D        = d_c;
   assign bus.M        = m_c;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_id    = rd_id_q;

`ifdef SRAM_RAW_FORWARD_EN
   // The macro returns pre-write data on a same-row collision, so the written
   // word is captured here and merged over Q in the response cycle.
   logic             fwd_hit_q, fwd_hit_d;
   logic [WIDTH-1:0] fwd_d_q, fwd_m_q;

   always_comb begin : fwd_detect
      fwd_hit_d = wr_found && rd_found && (aa_c == ab_c);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         fwd_hit_q <= 1'b0;
         fwd_d_q   <= '0;
         fwd_m_q   <= '0;
      end else begin
         fwd_hit_q <= fwd_hit_d;
         fwd_d_q   <= d_c;
         fwd_m_q   <= m_c;
      end
   end

   assign bus.rd_data = fwd_hit_q ? ((bus.Q & fwd_m_q) | (fwd_d_q & ~fwd_m_q)) : bus.Q;
`else
   assign bus.rd_data = bus.Q;
`endif
endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_dual_port_arbiter
//
// Bench for sram_dual_port_arbiter: a behavioural SRAM macro drives Q, a
// reference model tracks round-robin pointers, a golden memory and the
// expected read responses, and a compare process checks every output on each
// falling edge. Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sram_dual_port_arbiter;
   localparam int WIDTH    = 128;
   localparam int NUM_ROWS = 4096;
   localparam int NUM_WR   = 2;
   localparam int NUM_RD   = 2;
   localparam int AW       = $clog2(NUM_ROWS);

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // ---------------- clock / reset / DUT ----------------
   always #5 clk = ~clk;

   sram_dual_port_arbiter_if #(
      .WIDTH(WIDTH), .NUM_ROWS(NUM_ROWS), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)
   ) bus ();

   sram_dual_port_arbiter #(
      .WIDTH(WIDTH), .NUM_ROWS(NUM_ROWS), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   // ---------------- SRAM macro: registered read, masked write ----------------
   logic [WIDTH-1:0] sram [NUM_ROWS];
   logic [WIDTH-1:0] q_r = '0;
   assign bus.Q = q_r;

   always @(posedge clk) begin
      if (!bus.REB) q_r <= sram[bus.AB];
      if (!bus.WEB) sram[bus.AA] <= (sram[bus.AA] & bus.M) | (bus.D & ~bus.M);
   end

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] ref_mem [NUM_ROWS];
   logic [WIDTH-1:0] exp_q[$];
   int               m_wr_ptr = 0;
   int               m_rd_ptr = 0;
   int               m_rid    = 0;
   bit               m_rv     = 1'b0;

   function automatic int rr_pick(input logic [7:0] req, input int ptr, input int n);
      for (int i = 0; i < n; i++) begin
         int k;
         k = (ptr + i) % n;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [AW-1:0] wr_a(input int c);
      return bus.wr_addr[c*AW +: AW];
   endfunction

   function automatic logic [WIDTH-1:0] wr_d(input int c);
      return bus.wr_data[c*WIDTH +: WIDTH];
   endfunction

   function automatic logic [WIDTH-1:0] wr_m(input int c);
      return bus.wr_mask[c*WIDTH +: WIDTH];
   endfunction

   function automatic logic [AW-1:0] rd_a(input int c);
      return bus.rd_addr[c*AW +: AW];
   endfunction

   // Bitwise: a mask bit of 1 keeps the old bit, 0 takes the new one.
   function automatic logic [WIDTH-1:0] apply_write(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [WIDTH-1:0] keep);
      logic [WIDTH-1:0] r;
      for (int b = 0; b < WIDTH; b++) r[b] = keep[b] ? old_v[b] : new_v[b];
      return r;
   endfunction

   // Model advances on each rising edge using the pre-edge requests.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_wr_ptr = 0;
            m_rd_ptr = 0;
            m_rv     = 1'b0;
            m_rid    = 0;
            exp_q.delete();
         end else begin
            int w, r;
            logic [WIDTH-1:0] v;
            w = rr_pick(8'(bus.wr_req), m_wr_ptr, NUM_WR);
            r = rr_pick(8'(bus.rd_req), m_rd_ptr, NUM_RD);
            if (m_rv && exp_q.size() > 0) void'(exp_q.pop_front());
            m_rv = 1'b0;
            if (r >= 0) begin
               v = ref_mem[rd_a(r)];
`ifdef SRAM_RAW_FORWARD_EN
               if (w >= 0 && wr_a(w) == rd_a(r)) v = apply_write(v, wr_d(w), wr_m(w));
`endif
               exp_q.push_back(v);
               m_rv     = 1'b1;
               m_rid    = r;
               m_rd_ptr = (r + 1) % NUM_RD;
            end
            if (w >= 0) begin
               ref_mem[wr_a(w)] = apply_write(ref_mem[wr_a(w)], wr_d(w), wr_m(w));
               m_wr_ptr = (w + 1) % NUM_WR;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int w, r;
      if (rst) begin
         chk("cmp_rst_wr_gnt", WIDTH'(bus.wr_gnt), '0);
         chk("cmp_rst_rd_gnt", WIDTH'(bus.rd_gnt), '0);
         chk("cmp_rst_web", WIDTH'(bus.WEB), WIDTH'(1));
         chk("cmp_rst_reb", WIDTH'(bus.REB), WIDTH'(1));
         chk("cmp_rst_rd_valid", WIDTH'(bus.rd_valid), '0);
      end else begin
         w = rr_pick(8'(bus.wr_req), m_wr_ptr, NUM_WR);
         r = rr_pick(8'(bus.rd_req), m_rd_ptr, NUM_RD);
         chk("cmp_wr_gnt", WIDTH'(bus.wr_gnt), (w >= 0) ? WIDTH'(1) << w : '0);
         chk("cmp_web", WIDTH'(bus.WEB), (w >= 0) ? '0 : WIDTH'(1));
         chk("cmp_aa", WIDTH'(bus.AA), (w >= 0) ? WIDTH'(wr_a(w)) : '0);
         chk("cmp_d", bus.D, (w >= 0) ? wr_d(w) : '0);
         chk("cmp_m", bus.M, (w >= 0) ? wr_m(w) : '0);
         chk("cmp_rd_gnt", WIDTH'(bus.rd_gnt), (r >= 0) ? WIDTH'(1) << r : '0);
         chk("cmp_reb", WIDTH'(bus.REB), (r >= 0) ? '0 : WIDTH'(1));
         chk("cmp_ab", WIDTH'(bus.AB), (r >= 0) ? WIDTH'(rd_a(r)) : '0);
         chk("cmp_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(m_rv));
         if (m_rv) begin
            chk("cmp_rd_id", WIDTH'(bus.rd_id), WIDTH'(m_rid));
            if (exp_q.size() == 0) chk("cmp_exp_q_empty", WIDTH'(0), WIDTH'(1));
            else chk("cmp_rd_data", bus.rd_data, exp_q[0]);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check_outputs();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_wr(input int c, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
      bus.wr_req[c]                = 1'b1;
      bus.wr_addr[c*AW +: AW]       = a;
      bus.wr_data[c*WIDTH +: WIDTH] = d;
      bus.wr_mask[c*WIDTH +: WIDTH] = m;
   endtask

   task automatic drv_rd(input int c, input logic [AW-1:0] a);
      bus.rd_req[c]          = 1'b1;
      bus.rd_addr[c*AW +: AW] = a;
   endtask

   task automatic idle();
      bus.wr_req = '0;
      bus.rd_req = '0;
   endtask

   task automatic report();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: sequence did not finish in time");
      report();
      $finish;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      bus.wr_req  = '0;
      bus.rd_req  = '0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_mask = '0;
      bus.rd_addr = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         sram[i]    = '0;
         ref_mem[i] = '0;
      end

      // Reset pulse released mid-cycle, no requests.
      #2 rst = 1'b1;
      #1;
      chk("rst_wr_gnt", WIDTH'(bus.wr_gnt), '0);
      chk("rst_rd_gnt", WIDTH'(bus.rd_gnt), '0);
      chk("rst_web", WIDTH'(bus.WEB), WIDTH'(1));
      chk("rst_reb", WIDTH'(bus.REB), WIDTH'(1));
      chk("rst_rd_valid", WIDTH'(bus.rd_valid), '0);
      chk("rst_rd_id", WIDTH'(bus.rd_id), '0);
      #10 rst = 1'b0;
      @(negedge clk);
      chk("idle_web", WIDTH'(bus.WEB), WIDTH'(1));
      chk("idle_reb", WIDTH'(bus.REB), WIDTH'(1));
      chk("idle_rd_valid", WIDTH'(bus.rd_valid), '0);
      chk("idle_wr_gnt", WIDTH'(bus.wr_gnt), '0);
      tick();

      // Round robin on both ports at once, four cycles.
      drv_wr(0, 12'd10, WIDTH'(32'h1), '0);
      drv_wr(1, 12'd11, WIDTH'(32'h2), '0);
      drv_rd(0, 12'd10);
      drv_rd(1, 12'd11);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rr_wr_gnt", WIDTH'(bus.wr_gnt), (i % 2 == 0) ? WIDTH'(1) : WIDTH'(2));
         chk("rr_rd_gnt", WIDTH'(bus.rd_gnt), (i % 2 == 0) ? WIDTH'(1) : WIDTH'(2));
         if (i > 0) chk("rr_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(1));
         tick();
      end
      idle();
      @(negedge clk);
      chk("rr_rd_valid_last", WIDTH'(bus.rd_valid), WIDTH'(1));
      chk("rr_rd_id_last", WIDTH'(bus.rd_id), WIDTH'(1));
      tick();

      // Client 0 writes 0xA5 to row 5, then client 1 reads it back.
      drv_wr(0, 12'd5, WIDTH'(32'hA5), '0);
      @(negedge clk);
      chk("wtr_wr_gnt", WIDTH'(bus.wr_gnt), WIDTH'(1));
      chk("wtr_web", WIDTH'(bus.WEB), '0);
      chk("wtr_aa", WIDTH'(bus.AA), WIDTH'(5));
      tick();
      idle();
      drv_rd(1, 12'd5);
      @(negedge clk);
      chk("wtr_rd_gnt", WIDTH'(bus.rd_gnt), WIDTH'(2));
      chk("wtr_reb", WIDTH'(bus.REB), '0);
      chk("wtr_ab", WIDTH'(bus.AB), WIDTH'(5));
      tick();
      idle();
      @(negedge clk);
      chk("wtr_rd_valid", WIDTH'(bus.rd_valid), WIDTH'(1));
      chk("wtr_rd_id", WIDTH'(bus.rd_id), WIDTH'(1));
      chk("wtr_rd_data", bus.rd_data, WIDTH'(32'hA5));
      tick();

      // Masked write: row 7 = 0xFF, then D = 0x00 with M = 0xF0 -> 0xF0.
      drv_wr(1, 12'd7, WIDTH'(32'hFF), '0);
      @(negedge clk);
      chk("mask_wr_gnt_a", WIDTH'(bus.wr_gnt), WIDTH'(2));
      tick();
      idle();
      drv_wr(0, 12'd7, '0, WIDTH'(32'hF0));
      @(negedge clk);
      chk("mask_wr_gnt_b", WIDTH'(bus.wr_gnt), WIDTH'(1));
      chk("mask_m", bus.M, WIDTH'(32'hF0));
      tick();
      idle();
      drv_rd(0, 12'd7);
      @(negedge clk);
      chk("mask_rd_gnt", WIDTH'(bus.rd_gnt), WIDTH'(1));
      tick();
      idle();
      @(negedge clk);
      chk("mask_rd_data", bus.rd_data, WIDTH'(32'hF0));
      chk("mask_rd_id", WIDTH'(bus.rd_id), '0);
      tick();

      // Same-cycle read and write to row 3 (holding 0x11).
      drv_wr(0, 12'd3, WIDTH'(32'h11), '0);
      @(negedge clk);
      chk("raw_prep_gnt", WIDTH'(bus.wr_gnt), WIDTH'(1));
      tick();
      idle();
      drv_wr(1, 12'd3, WIDTH'(32'h22), '0);
      drv_rd(1, 12'd3);
      @(negedge clk);
      chk("raw_wr_gnt", WIDTH'(bus.wr_gnt), WIDTH'(2));
      chk("raw_rd_gnt", WIDTH'(bus.rd_gnt), WIDTH'(2));
      tick();
      idle();
      @(negedge clk);
`ifdef SRAM_RAW_FORWARD_EN
      chk("raw_rd_data", bus.rd_data, WIDTH'(32'h22));
`else
      chk("raw_rd_data", bus.rd_data, WIDTH'(32'h11));
`endif
      chk("raw_rd_id", WIDTH'(bus.rd_id), WIDTH'(1));
      tick();
      drv_rd(0, 12'd3);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      chk("raw_after_rd_data", bus.rd_data, WIDTH'(32'h22));
      tick();

      // Reset lands between a read grant and its response edge.
      drv_wr(0, 12'd20, WIDTH'(32'h33), '0);
      drv_rd(1, 12'd3);
      @(negedge clk);
      chk("mrst_rd_gnt", WIDTH'(bus.rd_gnt), WIDTH'(2));
      chk("mrst_wr_gnt", WIDTH'(bus.wr_gnt), WIDTH'(1));
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_rd_valid", WIDTH'(bus.rd_valid), '0);
      chk("mrst_rd_gnt_held", WIDTH'(bus.rd_gnt), '0);
      chk("mrst_web_held", WIDTH'(bus.WEB), WIDTH'(1));
      #1 rst = 1'b0;
      drv_wr(1, 12'd21, WIDTH'(32'h44), '0);
      drv_rd(0, 12'd5);
      @(negedge clk);
      chk("post_rst_rd_gnt", WIDTH'(bus.rd_gnt), WIDTH'(1));
      chk("post_rst_wr_gnt", WIDTH'(bus.wr_gnt), WIDTH'(1));
      chk("post_rst_rd_valid", WIDTH'(bus.rd_valid), '0);
      tick();
      idle();
      @(negedge clk);
      chk("post_rst_resp_valid", WIDTH'(bus.rd_valid), WIDTH'(1));
      chk("post_rst_resp_id", WIDTH'(bus.rd_id), '0);
      chk("post_rst_resp_data", bus.rd_data, WIDTH'(32'hA5));
      tick();
      tick();
      tick();

      report();
      $finish;
   end
endmodule
